shadow_stack: RTL and testbench

- Hardware return-address stack: the responder at the far end of the push/pop interface driven by the call/return monitor FSM.
- A push stores the link-register value captured on a call. A pop returns the most recent entry one cycle later so the monitor can compare it against the live return address.
- Sits beside the monitor/observer in the mor1kx cappuccino security extension. Exposes occupancy and sticky error flags to the security register.

---
 rtl/shadow_stack_if.sv | 28 ++
 rtl/shadow_stack.sv | 88 ++++++++
 tb/tb_shadow_stack.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/shadow_stack_if.sv
// Push/pop request bundle between the call/return monitor and the shadow stack.
// Requests are fire-and-forget: st_en qualifies one operation per cycle; a pop answers with pop_valid one cycle later.
interface shadow_stack_if #(
    parameter int ADDR_W = 5
);
    logic              st_en;
    logic              st_push_pop;
    logic [31:0]       st_data_in;
    logic              st_clear;
    logic              err_ack;
    logic [31:0]       st_data_out;
    logic              pop_valid;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    modport master (
        output st_en, st_push_pop, st_data_in, st_clear, err_ack,
        input  st_data_out, pop_valid, count, empty, full, overflow, underflow
    );

    modport slave (
        input  st_en, st_push_pop, st_data_in, st_clear, err_ack,
        output st_data_out, pop_valid, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/shadow_stack.sv
// Hardware return-address stack answering the call/return monitor.
// Circular or drop-on-full overflow, POISON on empty pop, sticky error flags.
module shadow_stack #(
    parameter int          DEPTH        = 32,
    parameter int          ADDR_W       = 5,
    parameter bit          WRAP_ON_FULL = 1'b1,
    parameter logic [31:0] POISON       = 32'hFFFF_FFFF
) (
    input  logic            clk,
    input  logic            reset_n,
    shadow_stack_if.slave   sif
);
    localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] tp;
    logic [ADDR_W:0]   cnt;
    logic [31:0]       dout;
    logic              pv;
    logic              ovf;
    logic              unf;

    logic is_full;
    logic is_empty;
    logic do_push;
    logic do_pop;
    logic wr_en;

    assign is_full  = (cnt == FULL_CNT);
    assign is_empty = (cnt == '0);
    assign do_push  = sif.st_en &  sif.st_push_pop & ~sif.st_clear;
    assign do_pop   = sif.st_en & ~sif.st_push_pop & ~sif.st_clear;
    // In drop mode a full stack refuses the write; in circular mode tp wraps onto the oldest slot.
    assign wr_en    = do_push & (~is_full | WRAP_ON_FULL);

    // Storage is deliberately not reset; reset_n still blocks a write on the edge it aborts.
    always_ff @(posedge clk) begin
        if (wr_en && reset_n) begin
            mem[tp] <= sif.st_data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tp   <= '0;
            cnt  <= '0;
            dout <= '0;
            pv   <= 1'b0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else if (sif.st_clear) begin
            tp   <= '0;
            cnt  <= '0;
            dout <= '0;
            pv   <= 1'b0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else begin
            pv <= do_pop;
            if (wr_en) begin
                tp <= tp + 1'b1;
                if (!is_full) begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (do_pop) begin
                if (is_empty) begin
                    dout <= POISON;
                end else begin
                    dout <= mem[tp - 1'b1];
                    tp   <= tp - 1'b1;
                    cnt  <= cnt - 1'b1;
                end
            end
            // A flag being set on this edge wins over a coincident err_ack.
            ovf <= (ovf & ~sif.err_ack) | (do_push & is_full);
            unf <= (unf & ~sif.err_ack) | (do_pop & is_empty);
        end
    end

    assign sif.st_data_out = dout;
    assign sif.pop_valid   = pv;
    assign sif.count       = cnt;
    assign sif.empty       = is_empty;
    assign sif.full        = is_full;
    assign sif.overflow    = ovf;
    assign sif.underflow   = unf;
endmodule

// File: tb/tb_shadow_stack.sv
// Self-checking bench: three shadow_stack instances (32 circular, 4 circular, 4 drop)
// driven in lockstep and compared against queue-based reference stacks.
module tb_shadow_stack;
    localparam logic [31:0] POISON = 32'hFFFF_FFFF;

    logic clk;
    logic reset_n;

    logic        en;
    logic        pp;
    logic [31:0] din;
    logic        clr;
    logic        ack;

    int total;
    int bad;

    shadow_stack_if #(.ADDR_W(5)) if0 ();
    shadow_stack_if #(.ADDR_W(2)) if1 ();
    shadow_stack_if #(.ADDR_W(2)) if2 ();

    assign if0.st_en = en;  assign if0.st_push_pop = pp;  assign if0.st_data_in = din;
    assign if0.st_clear = clr;  assign if0.err_ack = ack;
    assign if1.st_en = en;  assign if1.st_push_pop = pp;  assign if1.st_data_in = din;
    assign if1.st_clear = clr;  assign if1.err_ack = ack;
    assign if2.st_en = en;  assign if2.st_push_pop = pp;  assign if2.st_data_in = din;
    assign if2.st_clear = clr;  assign if2.err_ack = ack;

    shadow_stack #(.DEPTH(32), .ADDR_W(5), .WRAP_ON_FULL(1'b1), .POISON(POISON)) u_big (
        .clk(clk), .reset_n(reset_n), .sif(if0.slave)
    );
    shadow_stack #(.DEPTH(4), .ADDR_W(2), .WRAP_ON_FULL(1'b1), .POISON(POISON)) u_wrap (
        .clk(clk), .reset_n(reset_n), .sif(if1.slave)
    );
    shadow_stack #(.DEPTH(4), .ADDR_W(2), .WRAP_ON_FULL(1'b0), .POISON(POISON)) u_drop (
        .clk(clk), .reset_n(reset_n), .sif(if2.slave)
    );

    // DUT outputs gathered per instance
    logic [31:0] g_dout [3];
    logic [5:0]  g_cnt  [3];
    logic        g_pv   [3];
    logic        g_emp  [3];
    logic        g_full [3];
    logic        g_ovf  [3];
    logic        g_unf  [3];

    assign g_dout[0] = if0.st_data_out;  assign g_dout[1] = if1.st_data_out;  assign g_dout[2] = if2.st_data_out;
    assign g_cnt[0]  = 6'(if0.count);    assign g_cnt[1]  = 6'(if1.count);    assign g_cnt[2]  = 6'(if2.count);
    assign g_pv[0]   = if0.pop_valid;    assign g_pv[1]   = if1.pop_valid;    assign g_pv[2]   = if2.pop_valid;
    assign g_emp[0]  = if0.empty;        assign g_emp[1]  = if1.empty;        assign g_emp[2]  = if2.empty;
    assign g_full[0] = if0.full;         assign g_full[1] = if1.full;         assign g_full[2] = if2.full;
    assign g_ovf[0]  = if0.overflow;     assign g_ovf[1]  = if1.overflow;     assign g_ovf[2]  = if2.overflow;
    assign g_unf[0]  = if0.underflow;    assign g_unf[1]  = if1.underflow;    assign g_unf[2]  = if2.underflow;

    // Reference model: each stack is a queue, back = most recent entry
    int          m_depth [3] = '{32, 4, 4};
    bit          m_wrap  [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] exp_q   [3][$];
    logic [31:0] m_dout  [3];
    bit          m_pv    [3];
    bit          m_ovf   [3];
    bit          m_unf   [3];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            exp_q[k].delete();
            m_dout[k] = '0;
            m_pv[k]   = 1'b0;
            m_ovf[k]  = 1'b0;
            m_unf[k]  = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            bit set_o;
            bit set_u;
            set_o = 1'b0;
            set_u = 1'b0;
            m_pv[k] = 1'b0;
            if (clr) begin
                exp_q[k].delete();
                m_dout[k] = '0;
                m_ovf[k]  = 1'b0;
                m_unf[k]  = 1'b0;
            end else begin
                if (en && pp) begin
                    if (exp_q[k].size() < m_depth[k]) begin
                        exp_q[k].push_back(din);
                    end else begin
                        set_o = 1'b1;
                        if (m_wrap[k]) begin
                            void'(exp_q[k].pop_front());
                            exp_q[k].push_back(din);
                        end
                    end
                end else if (en && !pp) begin
                    m_pv[k] = 1'b1;
                    if (exp_q[k].size() > 0) begin
                        m_dout[k] = exp_q[k].pop_back();
                    end else begin
                        m_dout[k] = POISON;
                        set_u = 1'b1;
                    end
                end
                m_ovf[k] = (m_ovf[k] && !ack) || set_o;
                m_unf[k] = (m_unf[k] && !ack) || set_u;
            end
        end
    endtask

    task automatic check_all(input string ph);
        for (int k = 0; k < 3; k++) begin
            int n;
            n = exp_q[k].size();
            check($sformatf("%s i%0d dout", ph, k),  g_dout[k],        m_dout[k]);
            check($sformatf("%s i%0d pv", ph, k),    32'(g_pv[k]),     32'(m_pv[k]));
            check($sformatf("%s i%0d count", ph, k), 32'(g_cnt[k]),    32'(n));
            check($sformatf("%s i%0d empty", ph, k), 32'(g_emp[k]),    32'(n == 0));
            check($sformatf("%s i%0d full", ph, k),  32'(g_full[k]),   32'(n == m_depth[k]));
            check($sformatf("%s i%0d ovf", ph, k),   32'(g_ovf[k]),    32'(m_ovf[k]));
            check($sformatf("%s i%0d unf", ph, k),   32'(g_unf[k]),    32'(m_unf[k]));
        end
    endtask

    // driver: present inputs on the falling edge, model and check just after the rising edge
    task automatic step(input string ph, input bit e, input bit p, input logic [31:0] d,
                        input bit c, input bit a);
        @(negedge clk);
        en = e; pp = p; din = d; clr = c; ack = a;
        @(posedge clk);
        model_step();
        #1;
        check_all(ph);
    endtask

    task automatic push(input string ph, input logic [31:0] d);
        step(ph, 1'b1, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop(input string ph);
        step(ph, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic idle(input string ph);
        step(ph, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        en = 1'b0; pp = 1'b0; din = '0; clr = 1'b0; ack = 1'b0;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle("reset");

        // LIFO order
        push("lifo", 32'h100);
        push("lifo", 32'h200);
        push("lifo", 32'h300);
        pop("lifo");
        check("lifo pop1 big", g_dout[0], 32'h300);
        pop("lifo");
        pop("lifo");
        check("lifo pop3 big", g_dout[0], 32'h100);
        idle("lifo idle");

        // underflow and err_ack precedence
        pop("unf");
        check("unf poison", g_dout[0], POISON);
        step("unf ack", 1'b0, 1'b0, '0, 1'b0, 1'b1);
        step("unf ack+pop", 1'b1, 1'b0, '0, 1'b0, 1'b1);
        check("unf sticky", 32'(g_unf[0]), 32'd1);
        step("unf ack2", 1'b0, 1'b0, '0, 1'b0, 1'b1);

        // overflow: circular vs drop on the depth-4 stacks
        for (int i = 1; i <= 6; i++) push("ovf push", 32'(i));
        for (int i = 0; i < 5; i++) pop("ovf pop");
        step("ovf ack", 1'b0, 1'b0, '0, 1'b0, 1'b1);

        // clear beats a same-cycle push
        push("clr", 32'h11);
        push("clr", 32'h22);
        push("clr", 32'h33);
        step("clr+push", 1'b1, 1'b1, 32'hABC, 1'b1, 1'b0);
        check("clr dout", g_dout[0], 32'h0);
        pop("clr pop");

        // asynchronous reset in the middle of a push burst
        for (int i = 0; i < 3; i++) push("rst burst", 32'hA000 + 32'(i));
        @(negedge clk);
        en = 1'b1; pp = 1'b1; din = 32'hDEAD;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async rst");
        en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        push("post rst", 32'h5A5A);
        pop("post rst");
        pop("post rst");

        // randomized traffic, alternating push-heavy and pop-heavy phases
        for (int i = 0; i < 1500; i++) begin
            bit e;
            bit p;
            bit c;
            bit a;
            e = ($urandom_range(0, 3) != 0);
            p = ((i / 150) % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
            c = ($urandom_range(0, 79) == 0);
            a = ($urandom_range(0, 7) == 0);
            step("rand", e, p, $urandom(), c, a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
